// File: rtl/nn_pkg.sv
// Shared types and constants for the nn output classification blocks.
package nn_pkg;

  localparam int NN_DW = 8;

  typedef logic signed [NN_DW-1:0] nn_score_t;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } argmax_state_t;

endpackage

// File: rtl/nn_relu.sv
// Combinational ReLU clamp: negative scores become zero, others pass through.
module nn_relu #(
  parameter int DW = 8
) (
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] dout
);

  assign dout = din[DW-1] ? '0 : din;

endmodule

// File: rtl/nn_argmax.sv
// Frame-wise running argmax over a stream of signed neuron scores, result on ready/valid.
// Optional macro NN_ARGMAX_RELU_EN clamps negative scores to zero before the compare.
module nn_argmax
  import nn_pkg::*;
#(
  parameter  int N_CLASSES = 10,
  parameter  int DW        = NN_DW,
  localparam int IDX_W     = $clog2(N_CLASSES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_class,
  output logic signed [DW-1:0] out_score,
  output logic                 err_len
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  argmax_state_t        state;
  logic [IDX_W-1:0]     cnt;
  logic signed [DW-1:0] best;
  logic [IDX_W-1:0]     best_idx;
  logic signed [DW-1:0] val;

`ifdef NN_ARGMAX_RELU_EN
  nn_relu #(.DW(DW)) u_relu (
    .din  (in_data),
    .dout (val)
  );
`else
  assign val = in_data;
`endif

  logic                 accept, at_last, take, close;
  logic signed [DW-1:0] nxt_best;
  logic [IDX_W-1:0]     nxt_idx;

  // Strict compare keeps the lowest index on ties; beat 0 always seeds the frame.
  assign accept   = in_valid & in_ready;
  assign at_last  = (cnt == LAST_IDX);
  assign take     = (cnt == '0) || (val > best);
  assign nxt_best = take ? val : best;
  assign nxt_idx  = take ? cnt : best_idx;
  assign close    = at_last | in_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      cnt       <= '0;
      best      <= '0;
      best_idx  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_score <= '0;
      err_len   <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        SCAN: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (close) begin
              out_class <= nxt_idx;
              out_score <= nxt_best;
              cnt       <= '0;
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              // Short frame or missing marker: both disagree between count and in_last.
              err_len   <= in_last ^ at_last;
            end else begin
              cnt      <= cnt + 1'b1;
              best     <= nxt_best;
              best_idx <= nxt_idx;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= SCAN;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
